// File: rtl/mips_hazard_ctrl.sv
// Hazard controller for a 5-stage MIPS pipeline: load-use stall, branch flush,
// operand-forwarding selects and saturating stall/flush event counters.
module mips_hazard_ctrl #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              ex_branch_taken,
    input  logic              hold,
    input  logic              cnt_clr,
    output logic              pc_we,
    output logic              ifid_we,
    output logic              idex_bubble,
    output logic              ifid_flush,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [REG_AW-1:0] r_ex_rs, r_ex_rt, r_ex_rd, r_mem_rd, r_wb_rd;
    logic              r_ex_rw, r_ex_mr, r_mem_rw, r_wb_rw;
    logic [CNT_W-1:0]  r_stall_cnt, r_flush_cnt;
    logic              w_luh;

    // Shadow pipeline of destination/RegWrite/MemRead through EX, MEM, WB
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_rs  <= '0;
            r_ex_rt  <= '0;
            r_ex_rd  <= '0;
            r_ex_rw  <= 1'b0;
            r_ex_mr  <= 1'b0;
            r_mem_rd <= '0;
            r_mem_rw <= 1'b0;
            r_wb_rd  <= '0;
            r_wb_rw  <= 1'b0;
        end else if (!hold) begin
            r_mem_rd <= r_ex_rd;
            r_mem_rw <= r_ex_rw;
            r_wb_rd  <= r_mem_rd;
            r_wb_rw  <= r_mem_rw;
            if (idex_bubble) begin
                r_ex_rs <= '0;
                r_ex_rt <= '0;
                r_ex_rd <= '0;
                r_ex_rw <= 1'b0;
                r_ex_mr <= 1'b0;
            end else begin
                r_ex_rs <= id_uses_rs ? id_rs : '0;
                r_ex_rt <= id_uses_rt ? id_rt : '0;
                r_ex_rd <= id_rd;
                r_ex_rw <= id_reg_write;
                r_ex_mr <= id_mem_read;
            end
        end
    end

    assign w_luh = r_ex_mr && (r_ex_rd != '0) &&
                   ((id_uses_rs && (r_ex_rd == id_rs)) ||
                    (id_uses_rt && (r_ex_rd == id_rt)));

    // Pipeline enables, priority hold > branch > load-use
    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        if (hold) begin
            pc_we   = 1'b0;
            ifid_we = 1'b0;
        end else if (ex_branch_taken) begin
            idex_bubble = 1'b1;
            ifid_flush  = 1'b1;
        end else if (w_luh) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    // Two cascaded 2:1 muxes: EX/MEM (youngest) overrides MEM/WB
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src);
        logic [1:0] sel;
        sel = 2'b00;
        if (r_wb_rw && (r_wb_rd != '0) && (r_wb_rd == src))
            sel = 2'b01;
        if (r_mem_rw && (r_mem_rd != '0) && (r_mem_rd == src))
            sel = 2'b10;
        return sel;
    endfunction

    always_comb begin
        fwd_a_sel = fwd_sel(r_ex_rs);
        fwd_b_sel = fwd_sel(r_ex_rt);
    end

    // Saturating event counters; clear wins and works even under hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (cnt_clr) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (!hold) begin
            if (w_luh && !ex_branch_taken && (r_stall_cnt != CNT_MAX))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (ex_branch_taken && (r_flush_cnt != CNT_MAX))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_mips_hazard_ctrl.sv
// Directed bench for mips_hazard_ctrl: forwarding distances, load-use stall,
// branch/hold interplay, mid-stall reset and counter saturation/clear.
module tb_mips_hazard_ctrl;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [REG_AW-1:0] id_rs, id_rt, id_rd;
    logic              id_uses_rs, id_uses_rt, id_reg_write, id_mem_read;
    logic              ex_branch_taken, hold, cnt_clr;
    logic              pc_we, ifid_we, idex_bubble, ifid_flush;
    logic [1:0]        fwd_a_sel, fwd_b_sel;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    int checks   = 0;
    int failures = 0;

    mips_hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .ex_branch_taken(ex_branch_taken), .hold(hold), .cnt_clr(cnt_clr),
        .pc_we(pc_we), .ifid_we(ifid_we),
        .idex_bubble(idex_bubble), .ifid_flush(ifid_flush),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Packs {pc_we, ifid_we, idex_bubble, ifid_flush}
    function automatic logic [3:0] ctl();
        return {pc_we, ifid_we, idex_bubble, ifid_flush};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input int rs, input int rt, input logic urs, input logic urt,
                          input int rd, input logic rw, input logic mr);
        id_rs        = REG_AW'(rs);
        id_rt        = REG_AW'(rt);
        id_uses_rs   = urs;
        id_uses_rt   = urt;
        id_rd        = REG_AW'(rd);
        id_reg_write = rw;
        id_mem_read  = mr;
        #1;
    endtask

    task automatic nop();
        set_id(0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        nop();
        tick(); tick(); tick();
    endtask

    initial begin
        rst = 1'b1; hold = 1'b0; cnt_clr = 1'b0; ex_branch_taken = 1'b0;
        nop();
        #12;
        chk("reset_ctl",   32'(ctl()),     32'hC);
        chk("reset_fwd",   32'({fwd_a_sel, fwd_b_sel}), 32'h0);
        chk("reset_cnts",  32'({stall_cnt, flush_cnt}), 32'h0);
        @(negedge clk); rst = 1'b0;
        tick();

        // add $3 ; sub $4,$3,$5 -> distance 1
        set_id(1, 2, 1, 1, 3, 1, 0); tick();
        set_id(3, 5, 1, 1, 4, 1, 0); tick();
        chk("dist1_fwd_a", 32'(fwd_a_sel), 32'h2);
        chk("dist1_fwd_b", 32'(fwd_b_sel), 32'h0);
        drain();

        // add $3 ; nop ; sub -> distance 2
        set_id(1, 2, 1, 1, 3, 1, 0); tick();
        nop(); tick();
        set_id(3, 5, 1, 1, 4, 1, 0); tick();
        chk("dist2_fwd_a", 32'(fwd_a_sel), 32'h1);
        drain();

        // add $3 ; nop ; nop ; sub -> distance 3, regfile
        set_id(1, 2, 1, 1, 3, 1, 0); tick();
        nop(); tick(); tick();
        set_id(3, 5, 1, 1, 4, 1, 0); tick();
        chk("dist3_fwd_a", 32'(fwd_a_sel), 32'h0);
        drain();

        // lw $2 ; add $6,$2,$7 -> one stall then MEM/WB forward
        set_id(1, 0, 1, 0, 2, 1, 1); tick();
        set_id(2, 7, 1, 1, 6, 1, 0);
        chk("luh_ctl",      32'(ctl()), 32'h2);
        tick();
        chk("luh_stallcnt", 32'(stall_cnt), 32'h1);
        chk("luh_after_ctl", 32'(ctl()), 32'hC);
        tick();
        chk("luh_fwd_a",    32'(fwd_a_sel), 32'h1);
        chk("luh_no_more",  32'(ctl()), 32'hC);
        chk("luh_cnt_hold", 32'(stall_cnt), 32'h1);
        drain();

        // add $8 ; add $8 ; or $9,$8,$8 -> youngest wins on both operands
        set_id(1, 2, 1, 1, 8, 1, 0); tick();
        set_id(1, 2, 1, 1, 8, 1, 0); tick();
        set_id(8, 8, 1, 1, 9, 1, 0); tick();
        chk("dbl_fwd_a", 32'(fwd_a_sel), 32'h2);
        chk("dbl_fwd_b", 32'(fwd_b_sel), 32'h2);
        drain();

        // writes to $0 (incl. a load) then a read of $0
        set_id(1, 2, 1, 1, 0, 1, 0); tick();
        set_id(1, 0, 1, 0, 0, 1, 1); tick();
        set_id(0, 0, 1, 1, 9, 1, 0);
        chk("r0_no_stall", 32'(ctl()), 32'hC);
        tick();
        chk("r0_fwd", 32'({fwd_a_sel, fwd_b_sel}), 32'h0);
        drain();

        // branch taken coinciding with load-use
        set_id(1, 0, 1, 0, 2, 1, 1); tick();
        set_id(2, 7, 1, 1, 6, 1, 0);
        ex_branch_taken = 1'b1; #1;
        chk("br_luh_ctl", 32'(ctl()), 32'hF);
        tick();
        ex_branch_taken = 1'b0; #1;
        chk("br_flushcnt", 32'(flush_cnt), 32'h1);
        chk("br_stallcnt", 32'(stall_cnt), 32'h1);
        drain();

        // add $10 ; lw $2,($10) ; dependent + branch under hold for 3 cycles
        set_id(1, 0, 1, 0, 10, 1, 0); tick();
        set_id(10, 0, 1, 0, 2, 1, 1); tick();
        set_id(2, 7, 1, 1, 6, 1, 0);
        ex_branch_taken = 1'b1; hold = 1'b1; #1;
        chk("hold_ctl", 32'(ctl()), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_ctl_n",  32'(ctl()), 32'h0);
            chk("hold_frozen", 32'(fwd_a_sel), 32'h2);
            chk("hold_cnts",   32'({stall_cnt, flush_cnt}), 32'h11);
        end
        hold = 1'b0; #1;
        chk("release_ctl", 32'(ctl()), 32'hF);
        tick();
        ex_branch_taken = 1'b0; #1;
        chk("release_cnts", 32'({stall_cnt, flush_cnt}), 32'h12);
        drain();

        // reset asserted during a load-use stall
        set_id(1, 0, 1, 0, 2, 1, 1); tick();
        set_id(2, 0, 1, 0, 6, 1, 0);
        chk("pre_rst_stall", 32'(ctl()), 32'h2);
        @(negedge clk); rst = 1'b1; #1;
        chk("midrst_ctl",  32'(ctl()), 32'hC);
        chk("midrst_cnts", 32'({stall_cnt, flush_cnt}), 32'h0);
        chk("midrst_fwd",  32'({fwd_a_sel, fwd_b_sel}), 32'h0);
        @(negedge clk); rst = 1'b0;
        nop(); tick();

        // 2^CNT_W+3 stall events saturate the counter
        set_id(2, 0, 1, 0, 2, 1, 1);
        for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
            tick();
            tick();
        end
        chk("stall_sat", 32'(stall_cnt), 32'hF);
        tick();
        chk("clr_pre_luh", 32'(ctl()), 32'h2);
        cnt_clr = 1'b1; tick();
        cnt_clr = 1'b0; #1;
        chk("clr_wins", 32'(stall_cnt), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mips_hazard_ctrl.md
# mips_hazard_ctrl

- Sequences the 5-stage MIPS pipeline's operand-forwarding muxes, stall and flush.
- Keeps its own pipelined shadow of destination register, RegWrite and MemRead through EX, MEM and WB.
- From that shadow it drives:
  - the 2-bit select of each ALU operand mux, built from two cascaded 2:1 muxes;
  - the PC and IF/ID write enables;
  - the ID/EX bubble and IF/ID flush controls.
- Sits beside the ID/EX pipeline register, fed by decode and by branch resolution in EX.

## Interface
Parameters:
- REG_AW, 5, register address width
- CNT_W, 16, width of performance counters

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-high reset
- id_rs, id_rt  in  REG_AW  source registers of instruction in ID
- id_uses_rs, id_uses_rt  in  1  corresponding source is actually read
- id_rd  in  REG_AW  destination of ID instruction (after RegDst)
- id_reg_write, id_mem_read  in  1  ID instruction writes regfile / is a load
- ex_branch_taken  in  1  branch/jump in EX resolved taken
- hold  in  1  global freeze (memory not ready)
- cnt_clr  in  1  synchronous clear of both counters
- pc_we, ifid_we  out  1  PC / IF/ID register write enables
- idex_bubble  out  1  load NOP into ID/EX this edge
- ifid_flush  out  1  load NOP into IF/ID this edge
- fwd_a_sel, fwd_b_sel  out  2  ALU operand A/B select: 00 regfile, 01 MEM/WB result, 10 EX/MEM result, 11 unused
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters

## Operation
Shadow registers:
- EX: ex_rs, ex_rt, ex_rd, ex_rw, ex_mr.
- MEM: mem_rd, mem_rw.
- WB: wb_rd, wb_rw.

Per clock edge, unless hold:
- MEM <= EX; WB <= MEM.
- If idex_bubble: EX <= all zero. Otherwise EX <= ID inputs.
- An unused source (id_uses_x=0) captures as register 0.

Under hold, all shadows and counters keep their values.

Load-use hazard, combinational:
- luh = ex_mr & (ex_rd != 0) & ((id_uses_rs & ex_rd == id_rs) | (id_uses_rt & ex_rd == id_rt)).

Control outputs, combinational, priority hold > branch > luh:
- hold: pc_we=0, ifid_we=0, idex_bubble=0, ifid_flush=0.
- ex_branch_taken: pc_we=1, ifid_we=1, ifid_flush=1, idex_bubble=1. luh is ignored, since the dependent instruction is squashed.
- luh: pc_we=0, ifid_we=0, idex_bubble=1, ifid_flush=0. This gives exactly one bubble, after which the load sits in MEM and forwarding covers the value.
- otherwise: pc_we=1, ifid_we=1, others 0.

Forwarding, combinational from shadows (operand A uses ex_rs, B uses ex_rt):
- 10 if mem_rw & mem_rd != 0 & mem_rd == src.
- else 01 if wb_rw & wb_rd != 0 & wb_rd == src.
- else 00.
- EX/MEM wins over MEM/WB when both match (youngest value).
- Register 0 never forwards.
- The register file writes in the first half-cycle, so no WB-to-ID bypass exists.

Counters:
- stall_cnt increments on each non-hold cycle with luh & ~ex_branch_taken.
- flush_cnt increments on each non-hold cycle with ex_branch_taken.
- Both saturate at all-ones.
- cnt_clr zeroes both and overrides an increment in the same cycle; it is honoured even under hold.

## Timing
- Reset (async assert, sync release): all shadows and both counters = 0.
- Output values with hold=0 and no branch: pc_we=1, ifid_we=1, idex_bubble=0, ifid_flush=0, fwd_a_sel=fwd_b_sel=00.
- Reset asserted mid-stall clears the stall immediately.
- Control and forwarding outputs are combinational from current shadows and inputs. They are valid before the same edge they act on, so there is zero latency.
- Load followed by a dependent instruction: 1 stall cycle, then fwd select 01 in the dependent instruction's EX cycle.
- ALU result producer followed by a consumer at distance 1 / 2 / 3: select 10 / 01 / 00 (regfile).
- Branch taken with hold=1: no flush that edge. EX is frozen, so the branch re-asserts and flushes on the first non-hold edge.

## Test plan
- Reset mid-operation: assert rst with shadows non-zero -> all shadows and counters cleared immediately; outputs at reset values above.
- add $3 then sub $4,$3,$5 -> in sub's EX cycle fwd_a_sel=10. Variant `add $3`, NOP, `sub $4,$3,$5` -> fwd_a_sel=01.
- Load-use: lw $2 then add $6,$2,$7 -> one cycle with pc_we=0, ifid_we=0, idex_bubble=1, stall_cnt=1. Next cycle fwd_a_sel=01, no further stall.
- Double hazard: add $8 then add $8 then or $9,$8,$8 -> or's EX has fwd_a_sel=fwd_b_sel=10. Writes to $0 followed by reads of $0 -> 00, no stall.
- Branch taken together with luh: ex_branch_taken=1 and luh true -> pc_we=1, ifid_flush=1, idex_bubble=1, flush_cnt+1, stall_cnt unchanged. Repeat with hold=1 -> all enables 0, shadows frozen for 3 cycles, flush occurs on release.
- Counters: force 2^CNT_W+3 stall events -> stall_cnt=all-ones. cnt_clr together with an event -> counter reads 0.
